// File: rtl/encore_arb_pkg.sv
// encore_arb_pkg
//   Shared definitions for the trace-FIFO write-port arbiter.
//   - ST_IDLE / ST_GRANT : arbiter FSM state encoding
//   - BEAT_CNT_W         : width of the in-burst beat counter (covers bursts up to 16 beats)
//   - arb_clog2()        : ceil(log2(value)), used to size requester indices
package encore_arb_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    localparam int unsigned BEAT_CNT_W = 4;

    function automatic int unsigned arb_clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 1) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/encore_rr_picker.sv
// encore_rr_picker
//   Combinational cyclic-priority pick: returns the first asserted request strictly after
//   last_gnt, wrapping around, so last_gnt itself is chosen only when nobody else is asking.
// Ports
//   req       in   N_REQ  request vector
//   last_gnt  in   ID_W   index of the previous grantee (round-robin pointer)
//   any       out  1      at least one request asserted
//   index     out  ID_W   winning requester index (0 when any is low)
module encore_rr_picker
    import encore_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = arb_clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_gnt,
    output logic             any,
    output logic [ID_W-1:0]  index
);

    logic [ID_W-1:0] cand;

    always_comb begin
        any   = 1'b0;
        index = '0;
        cand  = '0;
        // Walk from the farthest offset to the nearest so the nearest hit is the final winner.
        for (int unsigned k = N_REQ; k >= 1; k--) begin
            cand = ID_W'((32'(last_gnt) + k) % N_REQ);
            if (req[cand]) begin
                any   = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/encore_fifo_arbiter.sv
// encore_fifo_arbiter
//   Round-robin arbiter sharing one trace-FIFO write port among N_REQ producers. A grantee keeps
//   the port for up to MAX_BURST beats; every beat is gated on FIFO headroom.
// Ports
//   s_axi_aclk        in   clock
//   s_axi_areset      in   synchronous active-high reset
//   arb_enable        in   allow new grants (an ongoing burst always completes)
//   req_valid/data    in   per-requester word available / word (requester i at [i*DATA_W +: DATA_W])
//   req_ready         out  per-requester accept; valid & ready = one beat
//   fifo_full         in   FIFO full
//   fifo_almost_full  in   FIFO almost full (covers the write in flight)
//   fifo_wr_data/en   out  registered FIFO write data / strobe
//   grant_valid       out  a requester holds the grant
//   grant_id          out  current or most recent grantee
//   fifo_stall        out  grantee has data but the FIFO has no headroom
//   wr_count          out  total beats written, wrapping
module encore_fifo_arbiter
    import encore_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned ID_W     = arb_clog2(N_REQ)
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_areset,
    input  logic                    arb_enable,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    fifo_full,
    input  logic                    fifo_almost_full,
    output logic [DATA_W-1:0]       fifo_wr_data,
    output logic                    fifo_wr_en,
    output logic                    grant_valid,
    output logic [ID_W-1:0]         grant_id,
    output logic                    fifo_stall,
    output logic [31:0]             wr_count
);

    logic                  state_q;
    logic [ID_W-1:0]       last_gnt_q;
    logic [ID_W-1:0]       grant_id_q;
    logic [BEAT_CNT_W-1:0] burst_cnt_q;
    logic [DATA_W-1:0]     wr_data_q;
    logic                  wr_en_q;
    logic [31:0]           wr_count_q;

    logic                  fifo_ok;
    logic                  sel_valid;
    logic [DATA_W-1:0]     sel_data;
    logic                  beat;
    logic                  last_beat;
    logic                  pick_any;
    logic [ID_W-1:0]       pick_idx;

    encore_rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req      (req_valid),
        .last_gnt (last_gnt_q),
        .any      (pick_any),
        .index    (pick_idx)
    );

    // almost_full already accounts for the registered write still in flight.
    assign fifo_ok = !fifo_full && !fifo_almost_full;

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        req_ready = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_id_q == ID_W'(i)) begin
                sel_valid = req_valid[i];
                sel_data  = req_data[i*DATA_W +: DATA_W];
            end
            req_ready[i] = (state_q == ST_GRANT) && (grant_id_q == ID_W'(i)) && fifo_ok;
        end
    end

    assign beat      = (state_q == ST_GRANT) && sel_valid && fifo_ok;
    assign last_beat = (burst_cnt_q == BEAT_CNT_W'(MAX_BURST - 1));

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_q     <= ST_IDLE;
            last_gnt_q  <= ID_W'(N_REQ - 1);
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_count_q  <= '0;
        end else begin
            wr_en_q <= beat;
            if (beat) begin
                wr_data_q  <= sel_data;
                wr_count_q <= wr_count_q + 32'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (arb_enable && pick_any) begin
                        grant_id_q  <= pick_idx;
                        burst_cnt_q <= '0;
                        state_q     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (beat) begin
                        burst_cnt_q <= burst_cnt_q + BEAT_CNT_W'(1);
                        if (last_beat) begin
                            last_gnt_q <= grant_id_q;
                            state_q    <= ST_IDLE;
                        end
                    end else if (!sel_valid) begin
                        // Grantee has nothing to send: give the port back at once.
                        last_gnt_q <= grant_id_q;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fifo_wr_data = wr_data_q;
    assign fifo_wr_en   = wr_en_q;
    assign grant_valid  = (state_q == ST_GRANT);
    assign grant_id     = grant_id_q;
    assign fifo_stall   = (state_q == ST_GRANT) && sel_valid && !fifo_ok;
    assign wr_count     = wr_count_q;

endmodule
